// File: rtl/prog_stream_loader.sv
// prog_stream_loader
//
// Streams a flat program image into the CPU instruction memory one word at a
// time. The image is written over a write port that has backpressure. The
// CPU is held in reset while the load runs. The loader then releases the CPU
// and supervises the run until the CPU halts or the cycle limit expires.
// The block is reused for every program load, not only at power-up.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   : checksum is the modulo-2^WORD_W sum of every transferred word.
//   undefined : no adder is built and checksum is tied to 0.
//
// Ports
//   clk        in   single clock, every register updates on posedge
//   rst        in   synchronous active-low reset
//   image      in   DEPTH*WORD_W flat image, word i = image[i*WORD_W +: WORD_W]
//   num_words  in   number of words to load, sampled together with start
//   start      in   begins a load; honoured only in IDLE or DONE
//   wr_en      out  instruction-memory write request
//   wr_addr    out  word address of the current write
//   wr_data    out  data of the current write
//   wr_ready   in   memory accepts the write when high together with wr_en
//   halt       in   CPU halt indication, looked at only in RUN
//   cpu_rst    out  active-high CPU reset, low only in RUN
//   busy       out  high in LOAD, RELEASE and RUN
//   done       out  run finished; held until the next start or reset
//   timeout    out  run was ended by the cycle limit (valid with done)
//   run_count  out  cycles spent in RUN, saturating
//   checksum   out  sum of the transferred words (see macro above)

module prog_stream_loader #(
    parameter int WORD_W     = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = 10,
    parameter int RUN_CYCLES = 28
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DEPTH*WORD_W-1:0] image,
    input  logic [ADDR_W:0]         num_words,
    input  logic                    start,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [WORD_W-1:0]       wr_data,
    input  logic                    wr_ready,
    input  logic                    halt,
    output logic                    cpu_rst,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout,
    output logic [31:0]             run_count,
    output logic [WORD_W-1:0]       checksum
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RELEASE = 3'd2,
        RUN     = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_N  = (ADDR_W + 1)'(DEPTH);
    localparam logic [31:0]     LIMIT_M1 = 32'(RUN_CYCLES - 1);

    state_t              state_q;
    logic [ADDR_W:0]     n_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [WORD_W-1:0]   wr_data_q;
    logic                cpu_rst_q;
    logic                busy_q;
    logic                done_q;
    logic                timeout_q;
    logic [31:0]         run_count_q;

    logic [ADDR_W:0]     n_d;
    logic [ADDR_W-1:0]   next_addr_d;
    logic                last_word_d;
    logic [31:0]         run_count_d;
    logic                limit_hit_d;

    // Word view of the flat image. The word is picked live whenever it is
    // presented, so image edits after start are honoured.
    logic [WORD_W-1:0]   words [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_words
        assign words[gi] = image[gi*WORD_W +: WORD_W];
    end

    assign n_d         = (num_words > DEPTH_N) ? DEPTH_N : num_words;
    assign next_addr_d = wr_addr_q + 1'b1;
    // wr_addr doubles as the load index. This keeps it within 0..n-1 by construction.
    assign last_word_d = ({1'b0, wr_addr_q} == (n_q - 1'b1));
    assign run_count_d = (run_count_q == 32'hFFFF_FFFF) ? run_count_q : run_count_q + 32'd1;
    assign limit_hit_d = (RUN_CYCLES != 0) && (run_count_q == LIMIT_M1);

`ifdef LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] checksum_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            checksum_q <= '0;
        end else if ((state_q == IDLE || state_q == DONE) && start) begin
            checksum_q <= '0;
        end else if (state_q == LOAD && wr_en_q && wr_ready) begin
            checksum_q <= checksum_q + wr_data_q;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            n_q         <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            cpu_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            run_count_q <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        n_q       <= n_d;
                        wr_addr_q <= '0;
                        done_q    <= 1'b0;
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b1;
                        if (n_d == '0) begin
                            state_q <= RELEASE;
                        end else begin
                            state_q   <= LOAD;
                            wr_en_q   <= 1'b1;
                            wr_data_q <= words[0];
                        end
                    end
                end
                LOAD: begin
                    // Address and data stay put until the memory takes them.
                    if (wr_ready) begin
                        if (last_word_d) begin
                            wr_en_q <= 1'b0;
                            state_q <= RELEASE;
                        end else begin
                            wr_addr_q <= next_addr_d;
                            wr_data_q <= words[next_addr_d];
                        end
                    end
                end
                RELEASE: begin
                    run_count_q <= '0;
                    cpu_rst_q   <= 1'b0;
                    state_q     <= RUN;
                end
                RUN: begin
                    run_count_q <= run_count_d;
                    // Halt takes priority over the limit when both occur in the same cycle.
                    if (halt || limit_hit_d) begin
                        state_q   <= DONE;
                        timeout_q <= !halt;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        cpu_rst_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign cpu_rst   = cpu_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign run_count = run_count_q;

endmodule

// File: tb/tb_prog_stream_loader.sv
// Directed testbench for prog_stream_loader with the default parameters
// (WORD_W=32, DEPTH=1024, ADDR_W=10, RUN_CYCLES=28).
module tb_prog_stream_loader;

    localparam int WORD_W = 32;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    localparam logic [31:0] W0  = 32'h2001_0005;   // addi $1,$0,5
    localparam logic [31:0] W1  = 32'h2002_0002;   // addi $2,$0,2
    localparam logic [31:0] W2  = 32'h2003_0007;   // addi $3,$0,7
    localparam logic [31:0] W2B = 32'h2004_0009;   // replacement for word 2

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [DEPTH*WORD_W-1:0] image = '0;
    logic [ADDR_W:0]         num_words = '0;
    logic                    start = 1'b0;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [WORD_W-1:0]       wr_data;
    logic                    wr_ready = 1'b1;
    logic                    halt = 1'b0;
    logic                    cpu_rst;
    logic                    busy;
    logic                    done;
    logic                    timeout;
    logic [31:0]             run_count;
    logic [WORD_W-1:0]       checksum;

    int checks = 0;
    int errors = 0;

    int          xfer_addr [$];
    logic [31:0] xfer_data [$];

    prog_stream_loader dut (
        .clk       (clk),
        .rst       (rst),
        .image     (image),
        .num_words (num_words),
        .start     (start),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .halt      (halt),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .run_count (run_count),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    // Log a transfer if one will happen at the coming edge, then advance to
    // just after that edge.
    task automatic tick();
        if (wr_en === 1'b1 && wr_ready === 1'b1) begin
            xfer_addr.push_back(int'(wr_addr));
            xfer_data.push_back(wr_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        xfer_addr.delete();
        xfer_data.delete();
    endtask

    // Wait for RUN, then halt the CPU to finish the run.
    task automatic halt_run(input string name);
        int c;
        c = 0;
        while (cpu_rst !== 1'b0 && c < 3000) begin
            tick();
            c++;
        end
        halt = 1'b1;
        tick();
        halt = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_halt_done got=%0b exp=1 (waited %0d cycles)", name, done, c);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if ({wr_en, cpu_rst, busy, done, timeout} !== 5'b01000 || wr_addr !== '0 ||
            wr_data !== '0 || run_count !== '0 || checksum !== '0) begin
            errors++;
            $display("FAIL reset_values got en=%0b rst=%0b busy=%0b done=%0b to=%0b addr=%0d data=%h rc=%0d cs=%h exp en=0 rst=1 busy=0 done=0 to=0 addr=0 data=0 rc=0 cs=0",
                     wr_en, cpu_rst, busy, done, timeout, wr_addr, wr_data, run_count, checksum);
        end
        rst = 1'b1;
        tick();
        $display("test_reset: done");
    endtask

    task automatic test_load3();
        int c;
        image[0*32 +: 32] = W0;
        image[1*32 +: 32] = W1;
        image[2*32 +: 32] = W2;
        num_words = 11'd3;
        wr_ready  = 1'b1;
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 10'd0 || wr_data !== W0 || busy !== 1'b1 || cpu_rst !== 1'b1) begin
            errors++;
            $display("FAIL load3_first got en=%0b addr=%0d data=%h busy=%0b cpu_rst=%0b exp en=1 addr=0 data=%h busy=1 cpu_rst=1",
                     wr_en, wr_addr, wr_data, busy, cpu_rst, W0);
        end
        c = 0;
        while (wr_en === 1'b1 && c < 20) begin
            tick();
            c++;
        end
        checks++;
        if (c !== 3 || xfer_addr.size() !== 3) begin
            errors++;
            $display("FAIL load3_count got cycles=%0d xfers=%0d exp cycles=3 xfers=3", c, xfer_addr.size());
        end else begin
            checks++;
            if (xfer_addr[0] !== 0 || xfer_addr[1] !== 1 || xfer_addr[2] !== 2 ||
                xfer_data[0] !== W0 || xfer_data[1] !== W1 || xfer_data[2] !== W2) begin
                errors++;
                $display("FAIL load3_xfers got %0d:%h %0d:%h %0d:%h exp 0:%h 1:%h 2:%h",
                         xfer_addr[0], xfer_data[0], xfer_addr[1], xfer_data[1], xfer_addr[2], xfer_data[2], W0, W1, W2);
            end
        end
        // One RELEASE cycle with the CPU still in reset, then RUN.
        checks++;
        if (cpu_rst !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load3_release got cpu_rst=%0b busy=%0b exp cpu_rst=1 busy=1", cpu_rst, busy);
        end
        tick();
        checks++;
        if (cpu_rst !== 1'b0 || run_count !== 32'd0) begin
            errors++;
            $display("FAIL load3_run_entry got cpu_rst=%0b rc=%0d exp cpu_rst=0 rc=0", cpu_rst, run_count);
        end
        repeat (9) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        checks++;
        if (done !== 1'b1 || timeout !== 1'b0 || run_count !== 32'd10 || cpu_rst !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL load3_done got done=%0b to=%0b rc=%0d cpu_rst=%0b busy=%0b exp done=1 to=0 rc=10 cpu_rst=1 busy=0",
                     done, timeout, run_count, cpu_rst, busy);
        end
        checks++;
`ifdef LOADER_CHECKSUM_EN
        if (checksum !== 32'h6006_000E) begin
            errors++;
            $display("FAIL load3_checksum got=%h exp=6006000e", checksum);
        end
`else
        if (checksum !== 32'h0) begin
            errors++;
            $display("FAIL load3_checksum got=%h exp=0", checksum);
        end
`endif
        tick();
        checks++;
        if (done !== 1'b1 || run_count !== 32'd10) begin
            errors++;
            $display("FAIL load3_hold got done=%0b rc=%0d exp done=1 rc=10", done, run_count);
        end
        $display("test_load3: 3 words loaded, halted at run_count=%0d", run_count);
    endtask

    // Start from DONE, stall word 1 for two cycles, edit word 2 mid-load and
    // pulse start (with a different size) while loading.
    task automatic test_stall();
        int c;
        logic [ADDR_W-1:0] a0;
        logic [31:0]       d0;
        image[2*32 +: 32] = W2;
        num_words = 11'd3;
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || wr_en !== 1'b1) begin
            errors++;
            $display("FAIL stall_restart got done=%0b en=%0b exp done=0 en=1", done, wr_en);
        end
        image[2*32 +: 32] = W2B;
        num_words = 11'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        a0 = wr_addr;
        d0 = wr_data;
        wr_ready = 1'b0;
        repeat (2) begin
            tick();
            checks++;
            if (wr_addr !== a0 || wr_data !== d0 || wr_en !== 1'b1 || a0 !== 10'd1 || d0 !== W1) begin
                errors++;
                $display("FAIL stall_hold got en=%0b addr=%0d data=%h exp en=1 addr=1 data=%h", wr_en, wr_addr, wr_data, W1);
            end
        end
        wr_ready = 1'b1;
        c = 0;
        while (wr_en === 1'b1 && c < 20) begin
            tick();
            c++;
        end
        checks++;
        if (xfer_addr.size() !== 3) begin
            errors++;
            $display("FAIL stall_count got=%0d exp=3", xfer_addr.size());
        end else begin
            checks++;
            if (xfer_addr[1] !== 1 || xfer_data[1] !== W1 || xfer_addr[2] !== 2 || xfer_data[2] !== W2B) begin
                errors++;
                $display("FAIL stall_data got 1:%0d:%h 2:%0d:%h exp 1:%h 2:%h",
                         xfer_addr[1], xfer_data[1], xfer_addr[2], xfer_data[2], W1, W2B);
            end
        end
        halt_run("stall");
`ifdef LOADER_CHECKSUM_EN
        checks++;
        if (checksum !== (W0 + W1 + W2B)) begin
            errors++;
            $display("FAIL stall_checksum got=%h exp=%h", checksum, W0 + W1 + W2B);
        end
`endif
        $display("test_stall: 3 transfers with 2-cycle stall on word 1");
    endtask

    // No halt: the run ends on the limit. start pulsed during RUN is ignored.
    task automatic test_timeout();
        int c;
        int run_cycles;
        num_words = 11'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        run_cycles = 0;
        while (done !== 1'b1 && c < 200) begin
            if (cpu_rst === 1'b0) begin
                run_cycles++;
                start = (run_cycles == 5);
            end
            tick();
            start = 1'b0;
            c++;
        end
        checks++;
        if (run_cycles !== 28 || timeout !== 1'b1 || cpu_rst !== 1'b1 || run_count !== 32'd28 || done !== 1'b1) begin
            errors++;
            $display("FAIL timeout_end got run_cycles=%0d to=%0b cpu_rst=%0b rc=%0d done=%0b exp run_cycles=28 to=1 cpu_rst=1 rc=28 done=1",
                     run_cycles, timeout, cpu_rst, run_count, done);
        end
        $display("test_timeout: run ended after %0d cycles, timeout=%0b", run_cycles, timeout);
    endtask

    task automatic test_halt_limit();
        int c;
        num_words = 11'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while (!(cpu_rst === 1'b0 && run_count === 32'd27) && c < 200) begin
            tick();
            c++;
        end
        halt = 1'b1;
        tick();
        halt = 1'b0;
        checks++;
        if (done !== 1'b1 || timeout !== 1'b0 || run_count !== 32'd28) begin
            errors++;
            $display("FAIL halt_limit got done=%0b to=%0b rc=%0d exp done=1 to=0 rc=28", done, timeout, run_count);
        end
        $display("test_halt_limit: halt and limit together, timeout=%0b", timeout);
    endtask

    task automatic test_zero_words();
        int wr_seen;
        num_words = 11'd0;
        wr_seen = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_seen += int'(wr_en === 1'b1);
        checks++;
        if (wr_en !== 1'b0 || busy !== 1'b1 || cpu_rst !== 1'b1) begin
            errors++;
            $display("FAIL zero_release got en=%0b busy=%0b cpu_rst=%0b exp en=0 busy=1 cpu_rst=1", wr_en, busy, cpu_rst);
        end
        tick();
        wr_seen += int'(wr_en === 1'b1);
        checks++;
        if (cpu_rst !== 1'b0 || run_count !== 32'd0 || wr_seen !== 0) begin
            errors++;
            $display("FAIL zero_run got cpu_rst=%0b rc=%0d wr_seen=%0d exp cpu_rst=0 rc=0 wr_seen=0", cpu_rst, run_count, wr_seen);
        end
        halt_run("zero");
        $display("test_zero_words: no writes, straight to RUN");
    endtask

    task automatic test_max_words();
        int c;
        int bad;
        for (int i = 0; i < DEPTH; i++) image[i*32 +: 32] = 32'h1000_0000 + 32'(i * 7);
        num_words = 11'd2000;
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while (wr_en === 1'b1 && c < 3000) begin
            tick();
            c++;
        end
        checks++;
        if (xfer_addr.size() !== 1024) begin
            errors++;
            $display("FAIL max_count got=%0d exp=1024", xfer_addr.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 1024; i++)
                if (xfer_addr[i] !== i || xfer_data[i] !== 32'h1000_0000 + 32'(i * 7)) bad++;
            checks++;
            if (bad !== 0 || xfer_addr[1023] !== 1023) begin
                errors++;
                $display("FAIL max_seq got bad=%0d last_addr=%0d exp bad=0 last_addr=1023", bad, xfer_addr[1023]);
            end
        end
        halt_run("max");
        $display("test_max_words: %0d writes, clamped to DEPTH", xfer_addr.size());
    endtask

    task automatic test_reset_mid_load();
        int c;
        num_words = 11'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while (wr_addr !== 10'd5 && c < 50) begin
            tick();
            c++;
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({wr_en, cpu_rst, busy, done, timeout} !== 5'b01000 || wr_addr !== '0 ||
            wr_data !== '0 || run_count !== '0 || checksum !== '0) begin
            errors++;
            $display("FAIL midrst_values got en=%0b rst=%0b busy=%0b done=%0b to=%0b addr=%0d data=%h rc=%0d cs=%h exp 0 1 0 0 0 0 0 0 0",
                     wr_en, cpu_rst, busy, done, timeout, wr_addr, wr_data, run_count, checksum);
        end
        rst = 1'b1;
        tick();
        clear_log();
        num_words = 11'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while (wr_en === 1'b1 && c < 50) begin
            tick();
            c++;
        end
        checks++;
        if (xfer_addr.size() !== 4) begin
            errors++;
            $display("FAIL midrst_count got=%0d exp=4", xfer_addr.size());
        end else begin
            checks++;
            if (xfer_addr[0] !== 0 || xfer_addr[3] !== 3 || xfer_data[3] !== 32'h1000_0015) begin
                errors++;
                $display("FAIL midrst_xfers got first=%0d last=%0d:%h exp first=0 last=3:10000015",
                         xfer_addr[0], xfer_addr[3], xfer_data[3]);
            end
        end
        halt_run("midrst");
        $display("test_reset_mid_load: reload wrote %0d words", xfer_addr.size());
    endtask

    initial begin
        test_reset();
        test_load3();
        test_stall();
        test_timeout();
        test_halt_limit();
        test_zero_words();
        test_max_words();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
